// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, selects the next PC, runs the imem req/ack
// handshake and re-presents the held instruction across load-use stalls.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        wpcir,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] if_pc4,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] hold_inst, hold_inst_nxt;
    logic            pend_v, pend_v_nxt;
    logic [XLEN-1:0] pend_pc, pend_pc_nxt;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] sel_pc;
    logic [XLEN-1:0] next_pc;

    assign pc_plus4  = pc + PC_STEP;
    assign imem_addr = pc;
    assign if_pc4    = pc_plus4;

    // Live redirect select from ID; a captured delay-slot redirect overrides it.
    always_comb begin
        sel_pc = pc_plus4;
        case (pcsrc)
            2'b00: sel_pc = pc_plus4;
            2'b01: sel_pc = bpc;
            2'b10: sel_pc = rpc;
            2'b11: sel_pc = jpc;
            default: sel_pc = pc_plus4;
        endcase
    end

    assign next_pc = pend_v ? pend_pc : sel_pc;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            hold_inst <= '0;
            pend_v    <= 1'b0;
            pend_pc   <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            hold_inst <= hold_inst_nxt;
            pend_v    <= pend_v_nxt;
            pend_pc   <= pend_pc_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        hold_inst_nxt = hold_inst;
        pend_v_nxt    = pend_v;
        pend_pc_nxt   = pend_pc;
        imem_req      = 1'b0;
        if_inst       = NOP_INST;
        if_valid      = 1'b0;

        case (state)
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if_inst  = imem_rdata;
                    if_valid = 1'b1;
                    if (wpcir) begin
                        pc_nxt     = next_pc;
                        pend_v_nxt = 1'b0;
                    end else begin
                        hold_inst_nxt = imem_rdata;
                        state_nxt     = S_HOLD;
                    end
                end else if (wpcir && (pcsrc != 2'b00) && !pend_v) begin
                    // ID moves on while the delay slot is still in flight: remember the target.
                    pend_v_nxt  = 1'b1;
                    pend_pc_nxt = sel_pc;
                end
            end
            S_HOLD: begin
                if_inst  = hold_inst;
                if_valid = 1'b1;
                if (wpcir) begin
                    pc_nxt     = next_pc;
                    pend_v_nxt = 1'b0;
                    state_nxt  = S_REQ;
                end
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase

        // Reset forces a quiet interface regardless of state.
        if (!clrn) begin
            imem_req = 1'b0;
            if_inst  = NOP_INST;
            if_valid = 1'b0;
        end
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU. Sits directly upstream of the IF/ID pipeline register and drives its if_pc4/if_inst inputs.
- Owns the PC register and next-PC selection (pc+4, branch, jump-register, jump) for the delayed-branch ISA.
- Handles a variable-latency instruction-memory req/ack handshake and the load-use stall (wpcir).
- During a memory wait it emits NOP bubbles. During a stall it re-presents the held instruction, because the IF/ID register is free-running.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, bubble instruction presented while a fetch is outstanding.

Ports:
- clk  in  1  clock; all state updates on posedge.
- clrn  in  1  asynchronous active-low reset.
- pcsrc  in  2  next-PC select from ID: 00 pc+4, 01 bpc, 10 rpc, 11 jpc.
- bpc  in  32  branch target.
- rpc  in  32  jump-register target.
- jpc  in  32  jump target.
- wpcir  in  1  1 = pipeline may advance; 0 = load-use stall, hold PC.
- imem_addr  out  32  fetch address (= pc).
- imem_req  out  1  fetch request.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- imem_ack  in  1  same-cycle completion of the current request.
- if_pc4  out  32  pc+4 of the presented instruction, to IF/ID.
- if_inst  out  32  presented instruction, to IF/ID.
- if_valid  out  1  1 = if_inst is a real instruction; 0 = bubble.

Behaviour:
- State: pc[31:0]; FSM state {S_REQ, S_HOLD}; buffer hold_inst[31:0]; pending redirect pend_v plus pend_pc[31:0].
- Reset (clrn=0, async, may occur at any time):
  - pc=RESET_PC, state=S_REQ, pend_v=0, hold_inst=0.
  - While clrn=0: imem_req=0, if_inst=NOP_INST, if_valid=0, if_pc4=RESET_PC+4.
  - An outstanding request is abandoned; a late ack after reset is treated as a fresh ack for RESET_PC.
- Outputs are combinational from state and inputs. imem_addr=pc always. if_pc4=pc+4 (32-bit, wraps at 2^32).
- next_pc = pend_v ? pend_pc : mux(pcsrc; pc+4, bpc, rpc, jpc). When pend_v=1 it wins and live pcsrc is ignored.
- S_REQ: imem_req=1.
  - ack=0:
    - if_inst=NOP_INST, if_valid=0, pc holds.
    - If wpcir=1 and pcsrc!=00 and pend_v=0: pend_v<=1, pend_pc<=selected target. This captures a delay-slot redirect whose ID instruction will move on.
  - ack=1, wpcir=1:
    - if_inst=imem_rdata, if_valid=1.
    - pc<=next_pc, pend_v<=0, stay S_REQ.
    - Zero-wait memory gives one instruction per cycle.
  - ack=1, wpcir=0:
    - if_inst=imem_rdata, if_valid=1.
    - hold_inst<=imem_rdata, pc holds, go S_HOLD.
- S_HOLD: imem_req=0, if_inst=hold_inst, if_valid=1.
  - wpcir=0: stay; pc, pend and hold_inst unchanged.
  - wpcir=1: pc<=next_pc, pend_v<=0, go S_REQ.
- No redirect capture in S_HOLD or when wpcir=0: the stalled branch stays in ID and reasserts pcsrc.
- Any pcsrc capture that would occur while pend_v=1 is dropped; this cannot occur in a legal flow.
- Latency: fetch-to-present is 0 cycles after ack. PC update lands on the clock edge that consumes the instruction.
- No alignment check; pc[1:0] is passed through unchanged.

Test Plan:
- Reset, ack tied 1, wpcir=1, pcsrc=00 -> imem_addr sequence 0,4,8,12. if_pc4 = 4,8,12,16. if_valid=1 every cycle.
- pc=0x10, ack=0 for 3 cycles then 1, rdata=0x8C220004 -> 3 cycles with if_inst=0 and if_valid=0, pc stays 0x10. Then inst presented and pc becomes 0x14.
- Delay-slot fetch at 0x20 with ack=0, pcsrc=01, bpc=0x100 for one cycle then pcsrc=00; ack=1 two cycles later -> delay slot at 0x20 presented, then imem_addr=0x100.
- ack=1 at pc=0x40, rdata=0xAABBCCDD, wpcir=0 for 2 cycles -> if_inst=0xAABBCCDD and if_pc4=0x44 for 3 cycles, imem_req=0 in S_HOLD. When wpcir=1, pc becomes 0x44.
- pc=0xFFFF_FFFC, pcsrc=00, ack=1 -> if_pc4=0, next pc=0.
- Assert clrn=0 mid-wait with pend_v=1 -> pc=RESET_PC, pend cleared, imem_req=0. After release, first fetch is from RESET_PC.
